// File: rtl/axi_lite_master_pkg.sv
// Shared types for the AXI4-Lite master: request hook struct, FSM states and response codes.
package axi_lite_master_pkg;

  typedef struct packed {
    logic        wr_req;
    logic        rd_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_addr;
  } hook_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a hook_t request struct.
// Define AXI_MASTER_ASSERT_EN to compile in protocol SVA checks.
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  hook_t             CTRL,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  output logic [DATA_W-1:0] rdata_q,
  output logic [1:0]        bresp_q
);

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = AWVALID && AWREADY && !aw_done;
  assign w_hs  = WVALID && WREADY && !w_done;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // A B response ends the write even if one address/data channel never handshook.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      AWADDR  <= '0;
      WDATA   <= '0;
      ARADDR  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      bresp_q <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (CTRL.wr_req) begin
            AWADDR  <= ADDR_W'(CTRL.wr_addr);
            WDATA   <= DATA_W'(CTRL.wr_data);
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            BREADY  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WRITE;
          end else if (CTRL.rd_req) begin
            ARADDR  <= ADDR_W'(CTRL.rd_addr);
            ARVALID <= 1'b1;
            RREADY  <= 1'b1;
            state   <= READ;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (b_hs) begin
            bresp_q <= BRESP;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            AWADDR  <= '0;
            WDATA   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        READ: begin
          if (ar_hs) ARVALID <= 1'b0;
          if (r_hs) begin
            rdata_q <= RDATA;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_MASTER_ASSERT_EN
  aw_stable_a: assert property (@(posedge ACLK) disable iff (!ARESETn)
    (AWVALID && !AWREADY && !b_hs) |=> (AWVALID && $stable(AWADDR)))
    else $error("AWVALID/AWADDR changed before AWREADY");

  w_stable_a: assert property (@(posedge ACLK) disable iff (!ARESETn)
    (WVALID && !WREADY && !b_hs) |=> (WVALID && $stable(WDATA)))
    else $error("WVALID/WDATA changed before WREADY");

  ar_stable_a: assert property (@(posedge ACLK) disable iff (!ARESETn)
    (ARVALID && !ARREADY && !r_hs) |=> (ARVALID && $stable(ARADDR)))
    else $error("ARVALID/ARADDR changed before ARREADY");

  rw_exclusive_a: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)))
    else $error("write and read channels active together");

  no_valid_in_reset_a: assert property (@(posedge ACLK)
    !ARESETn |-> !(AWVALID || WVALID || ARVALID))
    else $error("VALID asserted during reset");
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master with a small behavioural AXI-Lite slave.
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  logic        ACLK;
  logic        ARESETn;
  hook_t       CTRL;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, rdataQ;
  logic [1:0]  BRESP, brespQ;

  int          testsRun = 0;
  int          testsFailed = 0;

  int          awStall = 0;
  bit          bFast = 1'b1;
  logic [31:0] rdataVal = 32'h0;
  logic [1:0]  brespVal = OKAY;
  int          awValidCycles;
  logic        awSeen, wSeen, arSeen;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .CTRL(CTRL),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .rdata_q(rdataQ), .bresp_q(brespQ)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave: AWREADY held off for awStall cycles; bFast lets B answer in the AW/W handshake cycle.
  always_comb begin
    AWREADY = (awValidCycles >= awStall);
    WREADY  = 1'b1;
    ARREADY = 1'b1;
    BVALID  = bFast ? ((awSeen || (AWVALID && AWREADY)) && (wSeen || (WVALID && WREADY)))
                    : (awSeen && wSeen);
    RVALID  = arSeen || (ARVALID && ARREADY);
    BRESP   = brespVal;
    RDATA   = rdataVal;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awValidCycles <= 0;
      awSeen <= 1'b0;
      wSeen  <= 1'b0;
      arSeen <= 1'b0;
    end else begin
      if (AWVALID && !AWREADY) awValidCycles <= awValidCycles + 1;
      else if (!AWVALID)       awValidCycles <= 0;
      if (AWVALID && AWREADY) awSeen <= 1'b1;
      if (WVALID && WREADY)   wSeen  <= 1'b1;
      if (ARVALID && ARREADY) arSeen <= 1'b1;
      if (BVALID && BREADY) begin
        awSeen <= 1'b0;
        wSeen  <= 1'b0;
      end
      if (RVALID && RREADY) arSeen <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] wa,
                               input logic [31:0] wd, input logic [31:0] ra);
    CTRL.wr_req  = wr;
    CTRL.rd_req  = rd;
    CTRL.wr_addr = wa;
    CTRL.wr_data = wd;
    CTRL.rd_addr = ra;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESETn = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) tick();

    checkOutput("rst AWVALID", 32'(AWVALID), 32'h0);
    checkOutput("rst WVALID",  32'(WVALID),  32'h0);
    checkOutput("rst BREADY",  32'(BREADY),  32'h0);
    checkOutput("rst ARVALID", 32'(ARVALID), 32'h0);
    checkOutput("rst RREADY",  32'(RREADY),  32'h0);
    checkOutput("rst AWADDR",  AWADDR, 32'h0);
    checkOutput("rst WDATA",   WDATA,  32'h0);
    checkOutput("rst ARADDR",  ARADDR, 32'h0);
    checkOutput("rst rdata_q", rdataQ, 32'h0);
    checkOutput("rst bresp_q", 32'(brespQ), 32'h0);
    ARESETn = 1'b1;

    // Single write against an always-ready slave.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("wr AWVALID", 32'(AWVALID), 32'h1);
    checkOutput("wr WVALID",  32'(WVALID),  32'h1);
    checkOutput("wr BREADY",  32'(BREADY),  32'h1);
    checkOutput("wr AWADDR",  AWADDR, 32'h10);
    checkOutput("wr WDATA",   WDATA,  32'hDEADBEEF);
    checkOutput("wr ARVALID", 32'(ARVALID), 32'h0);
    tick();
    checkOutput("wr done AWVALID", 32'(AWVALID), 32'h0);
    checkOutput("wr done WVALID",  32'(WVALID),  32'h0);
    checkOutput("wr done BREADY",  32'(BREADY),  32'h0);
    checkOutput("wr bresp_q",      32'(brespQ),  32'(OKAY));
    checkOutput("wr state",        32'(dut.state), 32'(IDLE));

    // Single read.
    rdataVal = 32'hCAFEBABE;
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("rd ARVALID", 32'(ARVALID), 32'h1);
    checkOutput("rd RREADY",  32'(RREADY),  32'h1);
    checkOutput("rd ARADDR",  ARADDR, 32'h20);
    checkOutput("rd AWVALID", 32'(AWVALID), 32'h0);
    tick();
    checkOutput("rd done ARVALID", 32'(ARVALID), 32'h0);
    checkOutput("rd done RREADY",  32'(RREADY),  32'h0);
    checkOutput("rd rdata_q",      rdataQ, 32'hCAFEBABE);

    // Both requests for one cycle: write wins, read is dropped.
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h11112222, 32'h40);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("both AWVALID", 32'(AWVALID), 32'h1);
    checkOutput("both ARVALID", 32'(ARVALID), 32'h0);
    checkOutput("both AWADDR",  AWADDR, 32'h30);
    tick();
    checkOutput("both wr done BREADY", 32'(BREADY), 32'h0);
    tick();
    checkOutput("both no read ARVALID", 32'(ARVALID), 32'h0);

    // Read held high through the write is issued in the following IDLE.
    rdataVal = 32'h0BADF00D;
    applyStimulus(1'b1, 1'b1, 32'h34, 32'h33334444, 32'h44);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h44);
    checkOutput("held AWVALID", 32'(AWVALID), 32'h1);
    tick();
    checkOutput("held wr done ARVALID", 32'(ARVALID), 32'h0);
    checkOutput("held wr done BREADY",  32'(BREADY),  32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("held ARVALID", 32'(ARVALID), 32'h1);
    checkOutput("held ARADDR",  ARADDR, 32'h44);
    tick();
    checkOutput("held rdata_q", rdataQ, 32'h0BADF00D);

    // AWREADY held low for 3 cycles, B only after both channels complete.
    awStall = 3;
    bFast   = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h50, 32'h55AA55AA, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("stall AWVALID c0", 32'(AWVALID), 32'h1);
    checkOutput("stall WVALID c0",  32'(WVALID),  32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("stall AWVALID c%0d", k), 32'(AWVALID), 32'h1);
      checkOutput($sformatf("stall AWADDR c%0d", k),  AWADDR, 32'h50);
      checkOutput($sformatf("stall WVALID c%0d", k),  32'(WVALID), 32'h0);
    end
    tick();
    checkOutput("stall AW done AWVALID", 32'(AWVALID), 32'h0);
    checkOutput("stall AW done BREADY",  32'(BREADY),  32'h1);
    tick();
    checkOutput("stall B done BREADY", 32'(BREADY), 32'h0);
    checkOutput("stall state", 32'(dut.state), 32'(IDLE));
    awStall = 0;
    bFast   = 1'b1;

    // SLVERR response is captured.
    brespVal = SLVERR;
    applyStimulus(1'b1, 1'b0, 32'h54, 32'h0000FFFF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("slverr bresp_q", 32'(brespQ), 32'(SLVERR));
    checkOutput("slverr BREADY",  32'(BREADY), 32'h0);
    checkOutput("slverr state",   32'(dut.state), 32'(IDLE));
    brespVal = OKAY;

    // Reset mid-WRITE aborts asynchronously, then a clean write follows.
    awStall = 10;
    applyStimulus(1'b1, 1'b0, 32'h58, 32'hA5A5A5A5, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("abort pre AWVALID", 32'(AWVALID), 32'h1);
    #2;
    ARESETn = 1'b0;
    #1;
    checkOutput("abort AWVALID", 32'(AWVALID), 32'h0);
    checkOutput("abort WVALID",  32'(WVALID),  32'h0);
    checkOutput("abort BREADY",  32'(BREADY),  32'h0);
    checkOutput("abort AWADDR",  AWADDR, 32'h0);
    checkOutput("abort WDATA",   WDATA,  32'h0);
    checkOutput("abort bresp_q", 32'(brespQ), 32'h0);
    awStall = 0;
    tick();
    ARESETn = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h60, 32'h12345678, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("post AWVALID", 32'(AWVALID), 32'h1);
    checkOutput("post AWADDR",  AWADDR, 32'h60);
    checkOutput("post WDATA",   WDATA,  32'h12345678);
    tick();
    checkOutput("post done BREADY", 32'(BREADY), 32'h0);
    checkOutput("post bresp_q",     32'(brespQ), 32'(OKAY));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
